// File: rtl/core_stream_bridge_if.sv
// Bus interface for core_stream_bridge: read FIFO, write FIFO and accelerator signals.
// The master modport is the bridge side; the slave modport is the surrounding system.
interface core_stream_bridge_if #(
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned NUM_CHANNEL_IN = 8
);
    // Read FIFO (standard, data valid the cycle after the pop)
    logic [NUM_CHANNEL_IN*DWIDTH-1:0] ff_rdata;
    logic                             ff_rdreq;
    logic                             ff_empty;

    // Write FIFO, {class, data}
    logic [DWIDTH:0]                  ff_wdata;
    logic                             ff_wrreq;
    logic                             ff_full;

    // Accelerator
    logic [NUM_CHANNEL_IN*DWIDTH-1:0] acc_data_in;
    logic                             acc_valid_in;
    logic [DWIDTH-1:0]                acc_data_out;
    logic                             acc_class;
    logic                             acc_valid_out;
    logic                             acc_done;

    modport master (
        input  ff_rdata,
        output ff_rdreq,
        input  ff_empty,
        output ff_wdata,
        output ff_wrreq,
        input  ff_full,
        output acc_data_in,
        output acc_valid_in,
        input  acc_data_out,
        input  acc_class,
        input  acc_valid_out,
        input  acc_done
    );

    modport slave (
        output ff_rdata,
        input  ff_rdreq,
        output ff_empty,
        input  ff_wdata,
        input  ff_wrreq,
        output ff_full,
        input  acc_data_in,
        input  acc_valid_in,
        output acc_data_out,
        output acc_class,
        output acc_valid_out,
        output acc_done
    );
endinterface

// File: rtl/core_stream_bridge.sv
// core_stream_bridge: pops pixel words from a read FIFO into an accelerator, one frame per
// start pulse, and buffers {class, data} results in an output queue drained to a write FIFO.
// Optional stall counter enabled by defining CORE_STREAM_BRIDGE_PERF_EN.
module core_stream_bridge #(
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned NUM_CHANNEL_IN = 8,
    parameter int unsigned WIDTH          = 56,
    parameter int unsigned HEIGHT         = 56,
    parameter int unsigned OUT_DEPTH      = 16,
    parameter int unsigned SLACK          = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow_err,
    output logic [31:0]          perf_stall,
    core_stream_bridge_if.master bus
);

    localparam int unsigned FRAME_BEATS = WIDTH * HEIGHT;
    localparam int unsigned BEAT_W      = $clog2(FRAME_BEATS + 1);
    localparam int unsigned PTR_W       = $clog2(OUT_DEPTH);
    localparam int unsigned OCC_W       = PTR_W + 1;
    localparam int unsigned PIX_W       = NUM_CHANNEL_IN * DWIDTH;
    localparam int unsigned ENTRY_W     = DWIDTH + 1;

    localparam logic [BEAT_W-1:0] BEATS_TOTAL = BEAT_W'(FRAME_BEATS);
    localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(FRAME_BEATS - 1);
    localparam logic [OCC_W-1:0]  OCC_DEPTH   = OCC_W'(OUT_DEPTH);
    localparam logic [OCC_W-1:0]  OCC_SLACK   = OCC_W'(SLACK);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWaitDone,
        StDrain
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic                done_seen_q;
    logic                start_frame;

    // Read path
    logic                rd_go;
    logic                rd_pend_q;
    logic [PIX_W-1:0]    acc_data_q;
    logic                acc_valid_q;

    // Output queue
    logic [ENTRY_W-1:0]  mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    free;
    logic                queue_empty, queue_full;
    logic                push_ok, pop, drop;
    logic                overflow_q;

    assign start_frame = (state_q == StIdle) && start;

    // Queue status and handshake decode
    assign queue_empty = (occ_q == '0);
    assign queue_full  = (occ_q == OCC_DEPTH);
    assign free        = OCC_DEPTH - occ_q;
    assign pop         = !queue_empty && !bus.ff_full;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok     = bus.acc_valid_out && (!queue_full || pop);
    assign drop        = bus.acc_valid_out && queue_full && !pop;

    // Pop only with room for results already heading our way, and never past the frame end.
    assign rd_go = (state_q == StRun) && !bus.ff_empty && (free >= OCC_SLACK)
                   && (beat_q < BEATS_TOTAL);

    assign bus.ff_rdreq     = rd_go;
    assign bus.ff_wrreq     = pop;
    assign bus.ff_wdata     = mem_q[rd_ptr_q];
    assign bus.acc_data_in  = acc_data_q;
    assign bus.acc_valid_in = acc_valid_q;
    assign busy             = (state_q != StIdle);
    assign overflow_err     = overflow_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and frame_done pulse
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rd_go && (beat_q == BEAT_LAST)) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (bus.acc_done || done_seen_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (queue_empty) begin
                    state_d    = StIdle;
                    frame_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat counter and early acc_done capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q      <= '0;
            done_seen_q <= 1'b0;
        end else begin
            if (start_frame) begin
                beat_q <= '0;
            end else if (rd_go) begin
                beat_q <= beat_q + 1'b1;
            end

            // acc_done can beat the last pop; remember it until WAIT_DONE uses it.
            if (start_frame || (state_q == StWaitDone)) begin
                done_seen_q <= 1'b0;
            end else if ((state_q == StRun) && bus.acc_done) begin
                done_seen_q <= 1'b1;
            end
        end
    end

    // Read pipeline: pop at T, FIFO data at T+1, registered to the accelerator for T+2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q   <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
        end else begin
            rd_pend_q   <= rd_go;
            acc_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                acc_data_q <= bus.ff_rdata;
            end
        end
    end

    // Output queue storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {bus.acc_class, bus.acc_data_out};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Sticky overflow flag: a result was dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef CORE_STREAM_BRIDGE_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of RUN cycles without a pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (start_frame) begin
            stall_q <= '0;
        end else if ((state_q == StRun) && !rd_go && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall = stall_q;
`else
    assign perf_stall = '0;
`endif

endmodule
